fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter sharing the single write port of the asynchronous FIFO among several write-domain requesters. It sits entirely in the write clock domain, directly in front of the FIFO write-pointer/full logic. It grants one requester at a time for a bounded burst and drives the FIFO's `write_inc` and write data. It stalls cleanly on `write_full`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `DATA_WIDTH`, default 8: FIFO word width.
- `MAX_BURST`, default 4: maximum words per grant; must be ≥1.

Ports:
- `write_clk` input, 1 bit: write-domain clock; all logic on its rising edge.
- `write_rst` input, 1 bit: reset, synchronous, active-high.
- `req_valid` input, NUM_REQ bits: requester i has a word on its data slice.
- `req_last` input, NUM_REQ bits: the word offered by requester i ends its burst.
- `req_data` input, NUM_REQ*DATA_WIDTH bits: requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output, NUM_REQ bits: one-hot or zero; the word of requester i is accepted this cycle.
- `write_full` input, 1 bit: FIFO full flag from the write-pointer block.
- `write_inc` output, 1 bit: FIFO write enable.
- `write_data` output, DATA_WIDTH bits: word presented to FIFO memory.
- `grant_id` output, clog2(NUM_REQ) bits: current/last owner index.
- `busy` output, 1 bit: high while in BURST.

## Operation
- FSM states: IDLE, BURST.
- Reset values: state=IDLE; `last_grant`=NUM_REQ-1, so requester 0 has first priority; `grant_id`=0; burst count=0. `req_ready`, `write_inc` and `busy` all read 0.
- IDLE:
  - If any `req_valid` is high, select the first requester with `req_valid` high, searching cyclically from `last_grant`+1 (mod NUM_REQ).
  - Register the selection as `grant_id`, clear the burst count, and go to BURST.
  - No transfer occurs in IDLE.
- BURST:
  - Transfer condition: xfer = `req_valid[grant_id]` & ~`write_full`.
  - On xfer: `write_inc`=1, `req_ready[grant_id]`=1, and the burst count increments.
  - `write_data` = `req_data` slice of `grant_id` at all times in BURST. It is 0 in IDLE.
  - Leave BURST when xfer occurs together with either `req_last[grant_id]`=1 or count+1 == MAX_BURST. On leaving, `last_grant`←`grant_id` and state→IDLE.
  - If the owner deasserts `req_valid`, the arbiter holds the grant and waits. There is no timeout, and other requesters are not serviced.
- `write_full`=1 blocks xfer. State, count and grant are all held.
- The burst count is clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
- `req_last` from non-owners is ignored.
- `req_valid` from non-owners is ignored except during IDLE arbitration.

## Timing
- `write_inc`, `req_ready` and `write_data` are combinational from the registered state, `grant_id`, `req_valid` and `write_full`. There is no registered output stage.
- Arbitration latency: 1 cycle in IDLE before the first transfer.
- Minimum grant turnaround: 1 IDLE cycle between bursts.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles.
- `write_rst` asserted mid-burst: the next edge forces IDLE, and any partial burst is abandoned. `write_inc` is 0 from that edge until 2 cycles after reset deasserts at the earliest.
- `write_full` is registered upstream. The FIFO gates `write_inc` with `~write_full` internally as well. This block must never assert `write_inc` while `write_full`=1.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `grant_count`, NUM_REQ*16 bits.
  - Each requester has a 16-bit counter of accepted words. It increments on each `req_ready[i]` and saturates at 16'hFFFF.
  - All counters clear on `write_rst`.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Single requester 2, `req_valid`=4'b0100 held, `req_last` never asserted, MAX_BURST=4, no full:
  - First `write_inc` 2 cycles after reset release.
  - Then 4 transfers, 1 IDLE cycle, then 4 transfers; pattern repeats.
  - `grant_id` stays 2.
- All four requesters valid continuously, `req_last`=1 on every word:
  - Grant order 0,1,2,3,0…
  - Exactly one word per grant, with `write_inc` high every other cycle.
- Requester 1 in BURST, `write_full` high for 3 cycles after its 2nd word:
  - `write_inc` stays 0 for those 3 cycles.
  - Words 3–4 follow once full clears.
  - Total 4 words, none lost or duplicated.
- Owner 0 drops `req_valid` for 5 cycles mid-burst while requester 3 is valid:
  - The grant stays 0 and `req_ready[3]` stays 0.
  - The burst resumes and completes before 3 is granted.
- `write_rst` pulsed after the 2nd word of a burst:
  - All outputs read 0 the following cycle.
  - With requesters 1 and 2 valid after reset, requester 1 is granted first (priority restarts at 0).
- With `FIFO_ARB_STATS_EN`, run scenario 2 for 40 cycles:
  - Each `grant_count` slice equals the number of `req_ready` pulses that requester received (5 each).
  - A forced 16'hFFFF stays 16'hFFFF on the next accept.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter for the write port of the async FIFO.
// Lives entirely in the write_clk domain. It grants one requester at a time for
// a burst of up to MAX_BURST words and stalls on write_full.
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester accepted-word
// counters on output grant_count.

`ifdef FIFO_ARB_STATS_EN
// Per-requester saturating 16-bit counter of accepted words.
module fifo_arb_stat_ctr (
    input  logic        write_clk,
    input  logic        write_rst,
    input  logic        inc,
    output logic [15:0] count
);
    // Count accepts and hold at all-ones instead of wrapping.
    always_ff @(posedge write_clk) begin
        if (write_rst)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule
`endif

module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          write_clk,
    input  logic                          write_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          write_full,
    output logic                          write_inc,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  last_grant;
    logic [CW-1:0]   burst_cnt;
    logic [IDW:0]    pick;      // {found, index}
    logic            xfer;
    logic            burst_end;

    // First valid requester searching cyclically from last+1; the lowest
    // offset is visited last so it wins.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     last);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (v[idx]) r = {1'b1, idx[IDW-1:0]};
        end
        return r;
    endfunction

    // Arbitration result and per-cycle transfer qualifiers.
    always_comb begin
        pick      = rr_pick(req_valid, last_grant);
        xfer      = (state == BURST) && req_valid[grant_id] && !write_full;
        burst_end = xfer && (req_last[grant_id] ||
                             (burst_cnt + 1'b1) == CW'(MAX_BURST));
    end

    // State register.
    always_ff @(posedge write_clk) begin
        if (write_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: arbitrate in IDLE, leave BURST on last word or burst cap.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick[IDW]) state_nx = BURST;
            BURST:   if (burst_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant owner, round-robin pointer and burst counter.
    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[IDW]) begin
                        grant_id  <= pick[IDW-1:0];
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (xfer)      burst_cnt  <= burst_cnt + 1'b1;
                    if (burst_end) last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

    // Outputs: purely combinational from registered state so a full flag or
    // dropped valid stalls the same cycle; data is zeroed outside BURST.
    always_comb begin
        write_inc  = 1'b0;
        req_ready  = '0;
        write_data = '0;
        busy       = (state == BURST);
        if (state == BURST) begin
            write_data          = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            write_inc           = xfer;
            req_ready[grant_id] = xfer;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        fifo_arb_stat_ctr u_ctr (
            .write_clk (write_clk),
            .write_rst (write_rst),
            .inc       (req_ready[i]),
            .count     (grant_count[i*16 +: 16])
        );
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (default parameters: 4 requesters,
// 8-bit data, bursts of 4). Inputs change on the falling edge; outputs are
// checked 1 time unit later, before the next rising edge.
module tb_fifo_write_arbiter;
    logic        write_clk = 1'b0;
    logic        write_rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        write_full, write_inc, busy;
    logic [7:0]  write_data;
    logic [1:0]  grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] grant_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int nwords;

    fifo_write_arbiter dut (
        .write_clk  (write_clk),
        .write_rst  (write_rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write_full (write_full),
        .write_inc  (write_inc),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs at the falling edge, settle, then return for checks.
    task automatic tick(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
        @(negedge write_clk);
        write_rst  = r;
        req_valid  = v;
        req_last   = l;
        write_full = f;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_inc"},   write_inc, 1'b0);
        chk({tag, "_ready"}, req_ready, 4'b0000);
        chk({tag, "_busy"},  busy,      1'b0);
    endtask

    task automatic chk_word(input string tag, input logic [1:0] g, input logic [7:0] d);
        chk({tag, "_inc"},   write_inc,  1'b1);
        chk({tag, "_grant"}, grant_id,   g);
        chk({tag, "_ready"}, req_ready,  4'b0001 << g);
        chk({tag, "_data"},  write_data, d);
    endtask

    initial begin
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset state.
        tick(1, 4'b0000, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        chk_idle("rst");
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_data", write_data, 8'h00);

        // Single requester 2 streaming: 1 arbitration cycle, then 4 words.
        tick(0, 4'b0100, 4'b0000, 0);
        chk_idle("s1_arb0");
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int w = 0; w < 4; w++) begin
                tick(0, 4'b0100, 4'b0000, 0);
                chk_word("s1_word", 2'd2, 8'hC2);
            end
            tick(0, 4'b0100, 4'b0000, 0);
            chk_idle("s1_gap");
            chk("s1_gap_grant", grant_id, 2'd2);
            chk("s1_gap_data", write_data, 8'h00);
        end

        // All requesters valid, single-word bursts: 0,1,2,3,0... every other cycle.
        tick(1, 4'b0000, 4'b0000, 0);
        for (int c = 0; c < 40; c++) begin
            tick(0, 4'b1111, 4'b1111, 0);
            if (c % 2 == 0) chk_idle("s2_arb");
            else chk_word("s2_word", 2'((c / 2) % 4), req_data[((c / 2) % 4) * 8 +: 8]);
        end
        tick(0, 4'b0000, 4'b0000, 0);
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < 4; i++) chk("s2_stat", grant_count[i*16 +: 16], 16'd5);
`endif

        // Requester 1 stalled by write_full for 3 cycles after its 2nd word.
        tick(1, 4'b0000, 4'b0000, 0);
        nwords = 0;
        tick(0, 4'b0010, 4'b0000, 0);
        chk_idle("s3_arb");
        for (int w = 0; w < 2; w++) begin
            req_data[15:8] = 8'h10 + 8'(w);
            tick(0, 4'b0010, 4'b0000, 0);
            chk_word("s3_pre", 2'd1, 8'h10 + 8'(w));
            nwords += int'(write_inc);
        end
        req_data[15:8] = 8'h12;
        for (int s = 0; s < 3; s++) begin
            tick(0, 4'b0010, 4'b0000, 1);
            chk("s3_full_inc", write_inc, 1'b0);
            chk("s3_full_ready", req_ready, 4'b0000);
            chk("s3_full_busy", busy, 1'b1);
            nwords += int'(write_inc);
        end
        for (int w = 2; w < 4; w++) begin
            req_data[15:8] = 8'h10 + 8'(w);
            tick(0, 4'b0010, 4'b0000, 0);
            chk_word("s3_post", 2'd1, 8'h10 + 8'(w));
            nwords += int'(write_inc);
        end
        tick(0, 4'b0000, 4'b0000, 0);
        chk_idle("s3_end");
        chk("s3_nwords", nwords, 4);
        req_data[15:8] = 8'hB1;

        // Owner 0 drops valid mid-burst; requester 3 must wait.
        tick(1, 4'b0000, 4'b0000, 0);
        tick(0, 4'b1001, 4'b0000, 0);
        chk_idle("s4_arb");
        for (int w = 0; w < 2; w++) begin
            tick(0, 4'b1001, 4'b0000, 0);
            chk_word("s4_pre", 2'd0, 8'hA0);
        end
        for (int s = 0; s < 5; s++) begin
            tick(0, 4'b1000, 4'b0000, 0);
            chk("s4_hold_ready", req_ready, 4'b0000);
            chk("s4_hold_grant", grant_id, 2'd0);
            chk("s4_hold_busy", busy, 1'b1);
        end
        for (int w = 0; w < 2; w++) begin
            tick(0, 4'b1001, 4'b0000, 0);
            chk_word("s4_post", 2'd0, 8'hA0);
        end
        tick(0, 4'b1000, 4'b0000, 0);
        chk_idle("s4_gap");
        tick(0, 4'b1000, 4'b0000, 0);
        chk_word("s4_next", 2'd3, 8'hD3);

        // Reset after the 2nd word of a burst; priority restarts at 0.
        tick(1, 4'b0000, 4'b0000, 0);
        tick(0, 4'b0100, 4'b0000, 0);
        chk_idle("s5_arb");
        for (int w = 0; w < 2; w++) begin
            tick(0, 4'b0100, 4'b0000, 0);
            chk_word("s5_pre", 2'd2, 8'hC2);
        end
        tick(1, 4'b0100, 4'b0000, 0);
        tick(1, 4'b0110, 4'b0000, 0);
        chk_idle("s5_rst");
        chk("s5_rst_grant", grant_id, 2'd0);
        chk("s5_rst_data", write_data, 8'h00);
        tick(0, 4'b0110, 4'b0000, 0);
        chk_idle("s5_arb2");
        tick(0, 4'b0110, 4'b0000, 0);
        chk_word("s5_first", 2'd1, 8'hB1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
